// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared data-memory port. Instruction fetch
// (imem) and the write buffer (dmem) post single-cycle request pulses; at
// most one transaction is outstanding and each response is routed back to
// its owner. Data side has priority, bounded by a starvation limit for fetch.
module mem_arbiter #(
  parameter int unsigned starve_limit = 4,
  parameter int unsigned cnt_width    = 3
) (
  input  logic        clk,
  input  logic        rst,
  // fetch request / response
  input  logic        imem_in_valid,
  input  logic        imem_in_fence,
  input  logic [31:0] imem_in_addr,
  input  logic [31:0] imem_in_wdata,
  input  logic [3:0]  imem_in_wstrb,
  output logic        imem_out_ready,
  output logic [31:0] imem_out_rdata,
  // write-buffer request / response
  input  logic        dmem_in_valid,
  input  logic        dmem_in_fence,
  input  logic [31:0] dmem_in_addr,
  input  logic [31:0] dmem_in_wdata,
  input  logic [3:0]  dmem_in_wstrb,
  output logic        dmem_out_ready,
  output logic [31:0] dmem_out_rdata,
  // shared memory port
  input  logic        mem_out_ready,
  input  logic [31:0] mem_out_rdata,
  output logic        mem_in_valid,
  output logic        mem_in_instr,
  output logic        mem_in_fence,
  output logic [31:0] mem_in_addr,
  output logic [31:0] mem_in_wdata,
  output logic [3:0]  mem_in_wstrb,
  output logic        proto_err
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  typedef struct packed {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  localparam logic [cnt_width-1:0] CntLimit = cnt_width'(starve_limit);

  state_e               state_q, state_d;
  logic                 ipend_vld_q, ipend_vld_d;
  logic                 dpend_vld_q, dpend_vld_d;
  req_t                 ipend_q, ipend_d;
  req_t                 dpend_q, dpend_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic                 proto_err_q, proto_err_d;

  req_t i_in, d_in, i_req, d_req, g_req;
  logic issue, i_busy, d_busy, i_new, d_new, i_cand, d_cand, grant_i, grant_d;

  // Candidate selection, grant, pending-buffer and counter next state.
  always_comb begin
    i_in    = '{fence: imem_in_fence, addr: imem_in_addr, wdata: imem_in_wdata,
                wstrb: imem_in_wstrb};
    d_in    = '{fence: dmem_in_fence, addr: dmem_in_addr, wdata: dmem_in_wdata,
                wstrb: dmem_in_wstrb};
    // Reset gates issue so mem_in stays quiet while rst is held.
    issue   = !rst && ((state_q == StIdle) || mem_out_ready);
    // A side is busy if it still owns an unanswered request.
    i_busy  = ipend_vld_q || ((state_q == StBusyI) && !mem_out_ready);
    d_busy  = dpend_vld_q || ((state_q == StBusyD) && !mem_out_ready);
    i_new   = imem_in_valid && !i_busy;
    d_new   = dmem_in_valid && !d_busy;
    i_cand  = ipend_vld_q || i_new;
    d_cand  = dpend_vld_q || d_new;
    i_req   = ipend_vld_q ? ipend_q : i_in;
    d_req   = dpend_vld_q ? dpend_q : d_in;
    grant_i = issue && i_cand && (!d_cand || (cnt_q == CntLimit));
    grant_d = issue && d_cand && !grant_i;
    g_req   = grant_i ? i_req : (grant_d ? d_req : '0);

    state_d = state_q;
    if (issue) begin
      if (grant_i)      state_d = StBusyI;
      else if (grant_d) state_d = StBusyD;
      else              state_d = StIdle;
    end

    ipend_vld_d = ipend_vld_q;
    ipend_d     = ipend_q;
    if (grant_i) begin
      ipend_vld_d = 1'b0;
    end else if (i_new) begin
      ipend_vld_d = 1'b1;
      ipend_d     = i_in;
    end

    dpend_vld_d = dpend_vld_q;
    dpend_d     = dpend_q;
    if (grant_d) begin
      dpend_vld_d = 1'b0;
    end else if (d_new) begin
      dpend_vld_d = 1'b1;
      dpend_d     = d_in;
    end

    cnt_d = cnt_q;
    if (grant_i || !i_cand) begin
      cnt_d = '0;
    end else if (grant_d && (cnt_q != CntLimit)) begin
      cnt_d = cnt_q + cnt_width'(1);
    end

    proto_err_d = proto_err_q || (imem_in_valid && i_busy) || (dmem_in_valid && d_busy);
  end

  // Memory request and owner-routed responses.
  always_comb begin
    mem_in_valid   = grant_i || grant_d;
    mem_in_instr   = grant_i;
    mem_in_fence   = g_req.fence;
    mem_in_addr    = g_req.addr;
    mem_in_wdata   = g_req.wdata;
    mem_in_wstrb   = g_req.wstrb;
    imem_out_ready = 1'b0;
    imem_out_rdata = '0;
    dmem_out_ready = 1'b0;
    dmem_out_rdata = '0;
    if (state_q == StBusyI) begin
      imem_out_ready = mem_out_ready;
      imem_out_rdata = mem_out_rdata;
    end else if (state_q == StBusyD) begin
      dmem_out_ready = mem_out_ready;
      dmem_out_rdata = mem_out_rdata;
    end
    proto_err = proto_err_q;
  end

  // State, pending buffers, starvation counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ipend_vld_q <= 1'b0;
      dpend_vld_q <= 1'b0;
      ipend_q     <= '0;
      dpend_q     <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ipend_vld_q <= ipend_vld_d;
      dpend_vld_q <= dpend_vld_d;
      ipend_q     <= ipend_d;
      dpend_q     <= dpend_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int Limit = 4;

  typedef struct packed {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 0, i_fence = 0, d_valid = 0, d_fence = 0;
  logic [31:0] i_addr = 0, i_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  i_wstrb = 0, d_wstrb = 0;
  logic        m_ready = 0;
  logic [31:0] m_rdata = 0;

  logic        imem_out_ready, dmem_out_ready;
  logic [31:0] imem_out_rdata, dmem_out_rdata;
  logic        mem_in_valid, mem_in_instr, mem_in_fence, proto_err;
  logic [31:0] mem_in_addr, mem_in_wdata;
  logic [3:0]  mem_in_wstrb;

  mem_arbiter #(.starve_limit(Limit), .cnt_width(3)) dut (
    .clk(clk), .rst(rst),
    .imem_in_valid(i_valid), .imem_in_fence(i_fence), .imem_in_addr(i_addr),
    .imem_in_wdata(i_wdata), .imem_in_wstrb(i_wstrb),
    .imem_out_ready(imem_out_ready), .imem_out_rdata(imem_out_rdata),
    .dmem_in_valid(d_valid), .dmem_in_fence(d_fence), .dmem_in_addr(d_addr),
    .dmem_in_wdata(d_wdata), .dmem_in_wstrb(d_wstrb),
    .dmem_out_ready(dmem_out_ready), .dmem_out_rdata(dmem_out_rdata),
    .mem_out_ready(m_ready), .mem_out_rdata(m_rdata),
    .mem_in_valid(mem_in_valid), .mem_in_instr(mem_in_instr), .mem_in_fence(mem_in_fence),
    .mem_in_addr(mem_in_addr), .mem_in_wdata(mem_in_wdata), .mem_in_wstrb(mem_in_wstrb),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data), waiting requests.
  int   m_owner;
  bit   m_ip, m_dp, m_err;
  req_t m_ipr, m_dpr;
  int   m_cnt;

  // Observations from the most recent cycle, for scenario-specific checks.
  logic        obs_valid, obs_instr, obs_fence, obs_iready, obs_dready;
  logic [31:0] obs_addr, obs_irdata;
  string       grants;
  int          cyc = 0;
  int          issue_cyc[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_ip = 0; m_dp = 0; m_err = 0; m_cnt = 0;
    m_ipr = '0; m_dpr = '0;
  endtask

  // One clock cycle: settle, compare against the model, advance on the edge.
  task automatic step();
    req_t ireq_in, dreq_in, ireq, dreq, g;
    bit can, ibusy, dbusy, inew, dnew, icand, dcand;
    int pick;
    logic [70:0] exp_mem;
    logic [32:0] exp_i, exp_d;
    logic        exp_err;
    #1;
    ireq_in = '{fence: i_fence, addr: i_addr, wdata: i_wdata, wstrb: i_wstrb};
    dreq_in = '{fence: d_fence, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
    pick = 0; inew = 0; dnew = 0; icand = 0; can = 0;
    exp_mem = '0; exp_i = '0; exp_d = '0; exp_err = 1'b0;
    if (!rst) begin
      can   = (m_owner == 0) || m_ready;
      ibusy = m_ip || (m_owner == 1 && !m_ready);
      dbusy = m_dp || (m_owner == 2 && !m_ready);
      inew  = i_valid && !ibusy;
      dnew  = d_valid && !dbusy;
      icand = m_ip || inew;
      dcand = m_dp || dnew;
      ireq  = m_ip ? m_ipr : ireq_in;
      dreq  = m_dp ? m_dpr : dreq_in;
      if (can) begin
        if (icand && dcand) pick = (m_cnt == Limit) ? 1 : 2;
        else if (icand)     pick = 1;
        else if (dcand)     pick = 2;
      end
      g = (pick == 1) ? ireq : dreq;
      if (pick != 0) exp_mem = {1'b1, pick == 1, g.fence, g.addr, g.wdata, g.wstrb};
      if (m_owner == 1) exp_i = {m_ready, m_ready ? m_rdata : m_rdata};
      if (m_owner == 2) exp_d = {m_ready, m_rdata};
      exp_err = m_err;
      if ((i_valid && ibusy) || (d_valid && dbusy)) m_err = 1'b1;
    end
    chk("mem_in", {mem_in_valid, mem_in_instr, mem_in_fence, mem_in_addr, mem_in_wdata,
                   mem_in_wstrb}, exp_mem);
    chk("imem_out", {imem_out_ready, imem_out_rdata}, exp_i);
    chk("dmem_out", {dmem_out_ready, dmem_out_rdata}, exp_d);
    chk("proto_err", proto_err, exp_err);
    obs_valid = mem_in_valid; obs_instr = mem_in_instr; obs_fence = mem_in_fence;
    obs_addr = mem_in_addr; obs_iready = imem_out_ready; obs_irdata = imem_out_rdata;
    obs_dready = dmem_out_ready;
    if (mem_in_valid) begin
      grants = {grants, mem_in_instr ? "I" : "D"};
      issue_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      if (can) m_owner = pick;
      if (pick == 1) m_ip = 0;
      else if (inew) begin m_ip = 1; m_ipr = ireq_in; end
      if (pick == 2) m_dp = 0;
      else if (dnew) begin m_dp = 1; m_dpr = dreq_in; end
      if (pick == 1 || !icand) m_cnt = 0;
      else if (pick == 2 && m_cnt < Limit) m_cnt++;
    end
    #1;
    i_valid = 0; d_valid = 0; i_fence = 0; d_fence = 0; m_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); step();
    rst = 0;
    grants = "";
    issue_cyc.delete();
  endtask

  initial begin
    model_reset();
    grants = "";

    // Reset state.
    do_reset();
    chk("reset_idle", {obs_valid, obs_iready, obs_dready}, 3'b000);

    // Fetch only, ready after two cycles.
    i_valid = 1; i_addr = 32'h100; step();
    chk("t1_issue", {obs_valid, obs_instr, obs_addr}, {2'b11, 32'h100});
    step();
    m_ready = 1; m_rdata = 32'hDEADBEEF; step();
    chk("t1_resp", {obs_iready, obs_irdata, obs_dready}, {1'b1, 32'hDEADBEEF, 1'b0});
    step();

    // Simultaneous pulses in IDLE: data first, fetch back-to-back.
    do_reset();
    i_valid = 1; i_addr = 32'h200; d_valid = 1; d_addr = 32'h300; d_wstrb = 4'hF; step();
    m_ready = 1; m_rdata = 32'h1111; step();
    m_ready = 1; m_rdata = 32'h2222; step();
    n_checks++;
    assert (grants == "DI" && issue_cyc.size() == 2 && issue_cyc[1] == issue_cyc[0] + 1)
      else begin n_fail++; $error("FAIL t2_order observed=%s expected=DI", grants); end

    // Starvation limit: D,D,D,D,I,D,D.
    do_reset();
    i_valid = 1; i_addr = 32'h4000; d_valid = 1; d_addr = 32'h10; step();
    for (int k = 0; k < 7; k++) begin
      m_ready = 1; m_rdata = 32'hA0 + k;
      if (k != 4 && k != 6) begin d_valid = 1; d_addr = 32'h20 + 32'(k); end
      step();
    end
    n_checks++;
    assert (grants == "DDDDIDD")
      else begin n_fail++; $error("FAIL t3_order observed=%s expected=DDDDIDD", grants); end
    chk("t3_no_err", proto_err, 1'b0);

    // Reset in BUSY_D, late ready is ignored.
    do_reset();
    d_valid = 1; d_addr = 32'h400; step();
    step();
    rst = 1; m_ready = 1; m_rdata = 32'h55; step();
    rst = 0; m_ready = 1; m_rdata = 32'h66; step();
    chk("t4_no_resp", {obs_dready, obs_valid}, 2'b00);

    // Second data pulse while the first is outstanding.
    do_reset();
    d_valid = 1; d_addr = 32'h500; step();
    d_valid = 1; d_addr = 32'h504; step();
    step();
    chk("t5_err_set", proto_err, 1'b1);
    m_ready = 1; step();
    step(); step();
    n_checks++;
    assert (grants == "D")
      else begin n_fail++; $error("FAIL t5_dropped observed=%s expected=D", grants); end
    chk("t5_err_sticky", proto_err, 1'b1);
    rst = 1; step();
    rst = 0; step();
    chk("t5_err_clear", proto_err, 1'b0);

    // Fence passes through; fetch issues on its ready cycle.
    do_reset();
    d_valid = 1; d_fence = 1; d_wstrb = 4'h0; d_addr = 32'h600; step();
    chk("t6_fence", {obs_valid, obs_instr, obs_fence}, 3'b101);
    step();
    m_ready = 1; i_valid = 1; i_addr = 32'h700; step();
    chk("t6_handoff", {obs_dready, obs_valid, obs_instr, obs_addr}, {3'b111, 32'h700});
    m_ready = 1; step();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      i_valid = ($urandom_range(0, 3) == 0);
      d_valid = ($urandom_range(0, 2) == 0);
      i_fence = $urandom_range(0, 1); d_fence = $urandom_range(0, 1);
      i_addr = $urandom; i_wdata = $urandom; i_wstrb = 4'($urandom);
      d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
      m_ready = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
